// File: rtl/cpu16_mem_arbiter.sv
// Three-port arbiter for the cpu16 single-port RAM: instruction fetch, data, debug/loader.
// One access per three cycles; dbg_halt freezes out the CPU ports so the debug port owns memory.
module cpu16_mem_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter bit DBG_PRIO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      gnt_id,
  output logic            busy,
  input  logic            dbg_halt,
  output logic            halted,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] last;
  logic [1:0] win;
  logic       win_vld;
  logic [2:0] elig;
  logic [2:0] rr_set;
  logic [1:0] cand;

  // Winner selection; the round-robin set excludes port 2 when it has strict priority.
  always_comb begin
    elig    = dbg_halt ? (req & 3'b100) : req;
    rr_set  = DBG_PRIO ? (elig & 3'b011) : elig;
    win     = 2'd0;
    win_vld = 1'b0;
    cand    = 2'd0;
    if (DBG_PRIO && elig[2]) begin
      win     = 2'd2;
      win_vld = 1'b1;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        cand = 2'((int'(last) + i) % 3);
        if (!win_vld && rr_set[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; request fields are latched only at grant time.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ack       <= 3'b000;
      gnt_id    <= 2'd3;
      busy      <= 1'b0;
      halted    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last      <= 2'd1;
    end else begin
      halted <= (dbg_halt && state == IDLE) || (gnt_id == 2'd2);
      case (state)
        IDLE: begin
          if (win_vld) begin
            mem_en    <= 1'b1;
            mem_we    <= we[win];
            mem_addr  <= addr[win*AW +: AW];
            mem_wdata <= wdata[win*DW +: DW];
            gnt_id    <= win;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          ack    <= 3'b001 << gnt_id;
        end
        RESP: begin
          ack    <= 3'b000;
          gnt_id <= 2'd3;
          busy   <= 1'b0;
          last   <= gnt_id;
        end
        default: ;
      endcase
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_cpu16_mem_arbiter.sv
// Directed bench for cpu16_mem_arbiter: one instance with debug priority, one without,
// each with its own RAM model; expected acks are queued at stimulus time and popped on ack.
module tb_cpu16_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we;
  logic [47:0] addr, wdata;
  logic        dbg_halt;
  logic        preload;

  logic [2:0]  ack_a, ack_b;
  logic [15:0] rdata_a, rdata_b;
  logic [1:0]  gnt_id_a, gnt_id_b;
  logic        busy_a, busy_b, halted_a, halted_b;
  logic        mem_en_a, mem_en_b, mem_we_a, mem_we_b;
  logic [15:0] mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
  logic [15:0] mem_rdata_a, mem_rdata_b;

  logic [15:0] ram_a [256];
  logic [15:0] ram_b [256];
  int          we_cnt = 0;

  always #5 clk = ~clk;

  cpu16_mem_arbiter #(.AW(16), .DW(16), .DBG_PRIO(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_a), .rdata(rdata_a), .gnt_id(gnt_id_a), .busy(busy_a),
    .dbg_halt(dbg_halt), .halted(halted_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  cpu16_mem_arbiter #(.AW(16), .DW(16), .DBG_PRIO(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack_b), .rdata(rdata_b), .gnt_id(gnt_id_b), .busy(busy_b),
    .dbg_halt(dbg_halt), .halted(halted_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Synchronous single-port RAMs: read data valid the cycle after mem_en.
  always @(posedge clk) begin
    if (preload) begin
      ram_a[8'h10] <= 16'hBEEF;
      ram_a[8'h30] <= 16'hCAFE;
    end else if (mem_en_a) begin
      if (mem_we_a) ram_a[mem_addr_a[7:0]] <= mem_wdata_a;
      else          mem_rdata_a <= ram_a[mem_addr_a[7:0]];
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      ram_b[8'h10] <= 16'hBEEF;
      ram_b[8'h30] <= 16'hCAFE;
    end else if (mem_en_b) begin
      if (mem_we_b) ram_b[mem_addr_b[7:0]] <= mem_wdata_b;
      else          mem_rdata_b <= ram_b[mem_addr_b[7:0]];
    end
  end

  always @(negedge clk) if (mem_we_a === 1'b1) we_cnt++;

  typedef struct {
    logic [1:0]  port;
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = both instances, 1 = priority instance only, 2 = round-robin instance only
  task automatic push(input int which, input logic [1:0] p, input bit c, input logic [15:0] d);
    exp_t e;
    e.port = p;
    e.chk  = c;
    e.data = d;
    if (which != 2) qa.push_back(e);
    if (which != 1) qb.push_back(e);
  endtask

  task automatic expect_acks(input int n, input int budget, input bit spacing);
    int   seen   = 0;
    int   cyc    = 0;
    int   last_t = -1;
    exp_t e;
    while (seen < n && cyc < budget) begin
      tick();
      cyc++;
      if (ack_b !== 3'b000) begin
        if (qb.size() == 0) chk("b_unexpected_ack", 32'(ack_b), 32'h0);
        else begin
          e = qb.pop_front();
          chk("b_ack", 32'(ack_b), 32'(3'b001 << e.port));
          chk("b_gnt_id", 32'(gnt_id_b), 32'(e.port));
          if (e.chk) chk("b_rdata", 32'(rdata_b), 32'(e.data));
        end
      end
      if (ack_a !== 3'b000) begin
        if (qa.size() == 0) chk("a_unexpected_ack", 32'(ack_a), 32'h0);
        else begin
          e = qa.pop_front();
          chk("a_ack", 32'(ack_a), 32'(3'b001 << e.port));
          chk("a_gnt_id", 32'(gnt_id_a), 32'(e.port));
          if (e.chk) chk("a_rdata", 32'(rdata_a), 32'(e.data));
        end
        if (spacing && last_t >= 0) chk("a_ack_spacing", 32'(cyc - last_t), 32'd3);
        last_t = cyc;
        seen++;
      end
    end
    if (seen < n) chk("a_ack_timeout", 32'(seen), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; dbg_halt = 1'b0; preload = 1'b0;
    #2 rst_n = 1'b1; preload = 1'b1;
    #1;
    chk("rst_ack", 32'(ack_a), 32'h0);
    chk("rst_mem_en", 32'(mem_en_a), 32'h0);
    chk("rst_mem_we", 32'(mem_we_a), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr_a), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata_a), 32'h0);
    chk("rst_gnt_id", 32'(gnt_id_a), 32'h3);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_halted", 32'(halted_a), 32'h0);
    tick();
    preload = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("idle_gnt_id", 32'(gnt_id_a), 32'h3);

    // Single read from port 0
    addr[15:0] = 16'h0010; we = 3'b000; req = 3'b001;
    push(0, 2'd0, 1'b1, 16'hBEEF);
    tick();
    chk("rd_mem_en", 32'(mem_en_a), 32'h1);
    chk("rd_mem_addr", 32'(mem_addr_a), 32'h10);
    chk("rd_mem_we", 32'(mem_we_a), 32'h0);
    chk("rd_gnt_id", 32'(gnt_id_a), 32'h0);
    chk("rd_busy", 32'(busy_a), 32'h1);
    chk("rd_ack_early", 32'(ack_a), 32'h0);
    expect_acks(1, 5, 1'b0);
    req = 3'b000;
    tick();
    chk("rd_done_ack", 32'(ack_a), 32'h0);
    chk("rd_done_busy", 32'(busy_a), 32'h0);
    chk("rd_done_gnt_id", 32'(gnt_id_a), 32'h3);
    chk("rd_done_mem_en", 32'(mem_en_a), 32'h0);

    // Port 1 write, then port 0 reads it back
    base = we_cnt;
    addr[31:16] = 16'h0020; wdata[31:16] = 16'h1234; we = 3'b010; req = 3'b010;
    push(0, 2'd1, 1'b0, 16'h0);
    expect_acks(1, 6, 1'b0);
    req = 3'b000; we = 3'b000;
    tick();
    chk("wr_mem_we_cycles", 32'(we_cnt - base), 32'd1);
    addr[15:0] = 16'h0020; req = 3'b001;
    push(0, 2'd0, 1'b1, 16'h1234);
    expect_acks(1, 6, 1'b0);
    req = 3'b000;
    tick();

    // Ports 0 and 1 held from reset: strict alternation, one ack every 3 cycles
    rst_n = 1'b1;
    tick();
    addr[15:0] = 16'h0010; addr[31:16] = 16'h0020; req = 3'b011;
    rst_n = 1'b0;
    push(0, 2'd0, 1'b1, 16'hBEEF);
    push(0, 2'd1, 1'b1, 16'h1234);
    push(0, 2'd0, 1'b1, 16'hBEEF);
    push(0, 2'd1, 1'b1, 16'h1234);
    expect_acks(4, 20, 1'b1);
    req = 3'b000;
    tick();

    // Port 2 alone, leaving last = 2 in both instances
    addr[47:32] = 16'h0030; req = 3'b100;
    push(0, 2'd2, 1'b1, 16'hCAFE);
    expect_acks(1, 6, 1'b0);
    req = 3'b000;
    tick();

    // All three requesting: strict priority vs round-robin
    req = 3'b111;
    for (int i = 0; i < 4; i++) push(1, 2'd2, 1'b1, 16'hCAFE);
    push(2, 2'd0, 1'b1, 16'hBEEF);
    push(2, 2'd1, 1'b1, 16'h1234);
    push(2, 2'd2, 1'b1, 16'hCAFE);
    push(2, 2'd0, 1'b1, 16'hBEEF);
    expect_acks(4, 20, 1'b1);
    req = 3'b000;
    tick();
    chk("prio_qa_empty", 32'(qa.size()), 32'h0);
    chk("prio_qb_empty", 32'(qb.size()), 32'h0);

    // Debug halt raised while a port 0 access is in flight
    addr[15:0] = 16'h0010; req = 3'b001;
    push(0, 2'd0, 1'b1, 16'hBEEF);
    tick();
    chk("halt_inflight_busy", 32'(busy_a), 32'h1);
    dbg_halt = 1'b1;
    expect_acks(1, 4, 1'b0);
    tick();
    tick();
    chk("halt_halted", 32'(halted_a), 32'h1);
    chk("halt_busy", 32'(busy_a), 32'h0);
    chk("halt_gnt_id", 32'(gnt_id_a), 32'h3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_no_grant", 32'({ack_a, ack_b, mem_en_a, mem_en_b}), 32'h0);
    end
    req = 3'b101;
    push(0, 2'd2, 1'b1, 16'hCAFE);
    expect_acks(1, 6, 1'b0);
    chk("halt_dbg_halted", 32'(halted_a), 32'h1);
    req = 3'b001;
    tick();
    dbg_halt = 1'b0;
    push(0, 2'd0, 1'b1, 16'hBEEF);
    tick();
    chk("unhalt_halted", 32'(halted_a), 32'h0);
    chk("unhalt_gnt_id", 32'(gnt_id_a), 32'h0);
    chk("unhalt_mem_en", 32'(mem_en_a), 32'h1);
    expect_acks(1, 4, 1'b0);
    req = 3'b000;
    tick();

    // Reset pulsed during ACCESS
    addr[15:0] = 16'h0010; req = 3'b001;
    tick();
    chk("rstmid_mem_en", 32'(mem_en_a), 32'h1);
    #1 rst_n = 1'b1;
    #1;
    chk("rstmid_ack", 32'(ack_a), 32'h0);
    chk("rstmid_busy", 32'(busy_a), 32'h0);
    chk("rstmid_gnt_id", 32'(gnt_id_a), 32'h3);
    chk("rstmid_mem_en_clr", 32'(mem_en_a), 32'h0);
    tick();
    chk("rstmid_no_ack", 32'({ack_a, ack_b}), 32'h0);
    rst_n = 1'b0;
    push(0, 2'd0, 1'b1, 16'hBEEF);
    expect_acks(1, 6, 1'b0);
    req = 3'b000;
    tick();

    chk("end_qa_empty", 32'(qa.size()), 32'h0);
    chk("end_qb_empty", 32'(qb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu16_mem_arbiter.md
Name: cpu16_mem_arbiter

Overview:
- Arbitrates one synchronous single-port 16-bit RAM between three cpu16 requesters.
- Port 0 is instruction fetch, port 1 is data load/store, port 2 is the debug/loader port.
- Also provides a debug halt: CPU ports are frozen out so the debug port owns memory while the core is stalled.
- Sits between the cpu16 core, the debug interface and the RAM.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- DBG_PRIO, 1, 1 = port 2 has strict priority over ports 0/1; 0 = port 2 joins the round-robin.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req  in  3  per-port request; held, with fields stable, until the matching ack.
- we  in  3  per-port write enable (1 = write).
- addr  in  3*AW  per-port address; port i uses bits [i*AW +: AW].
- wdata  in  3*DW  per-port write data; port i uses bits [i*DW +: DW].
- ack  out  3  one-cycle completion pulse per port.
- rdata  out  DW  read data, valid only while any ack bit is high.
- gnt_id  out  2  index of the port owning the current access; 3 = none.
- busy  out  1  access in flight.
- dbg_halt  in  1  block grants to ports 0 and 1.
- halted  out  1  dbg_halt accepted and no CPU-port access in flight.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en.

Behaviour:
- Interface: reset rst_n, asynchronous, active-high; clock clk. While rst_n = 1, all state is cleared.
- Reset values:
  - ack = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - gnt_id = 3, busy = 0, halted = 0.
  - FSM = IDLE; round-robin pointer last = 1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible set: req masked with ports 0/1 removed when dbg_halt = 1.
  - If the eligible set is non-empty, select a winner and register mem_en = 1, mem_we = we[w], mem_addr = addr[w], mem_wdata = wdata[w], gnt_id = w, busy = 1; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (one cycle):
  - mem_en and mem_we return to 0 at the end of this cycle.
  - Go to RESP; ack[w] is registered high for the RESP cycle.
- RESP (one cycle):
  - ack[w] = 1; rdata = mem_rdata (combinational pass-through). For writes, rdata is don't-care.
  - On exit: ack = 0, gnt_id = 3, busy = 0, last = w; go to IDLE.
- Timing:
  - req seen in IDLE at cycle 0 → mem_en high in cycle 1 → ack high in cycle 2 → next grant possible in cycle 3.
  - Peak throughput is one access per 3 cycles.
  - Requesters drop or update req on the edge that samples ack, so a stale req is never re-granted.
- Winner selection:
  - DBG_PRIO = 1 and req[2] eligible: w = 2.
  - Otherwise round-robin over the eligible ports, starting at (last+1) mod 3 and skipping port 2 when DBG_PRIO = 1.
  - last is updated only by completed accesses.
- dbg_halt:
  - Sampled only in IDLE; an in-flight CPU access always completes.
  - halted = 1 when dbg_halt = 1 and FSM = IDLE, or the in-flight gnt_id = 2. Registered; it updates one cycle after the condition.
  - Deasserting dbg_halt clears halted on the next cycle.
- Request lifetime:
  - A req dropped before its ack is a protocol violation; the access still completes and ack still pulses.
  - A req that changes address mid-access has no effect; fields are latched in IDLE.
- Reset asserted mid-access: the access is abandoned, no ack is issued, and all outputs return to reset values asynchronously.
- No combinational path from req to any output.

Test Plan:
- Single read, port 0 at addr 0x0010 (RAM holds 0xBEEF) → mem_en in cycle 1 with mem_addr = 0x0010, ack = 3'b001 in cycle 2, rdata = 0xBEEF, gnt_id = 0.
- Port 1 write 0x1234 to 0x0020, then port 0 reads 0x0020 → mem_we = 1 exactly one cycle; the read returns 0x1234.
- req = 3'b011 held continuously after reset → grants alternate 0,1,0,1; each ack spaced 3 cycles; no port starved.
- DBG_PRIO = 1, req = 3'b111 held → port 2 wins every arbitration while asserted; with DBG_PRIO = 0 the order is 0,1,2,0.
- Port 0 access in flight when dbg_halt rises → that access acks; port 0 is then not granted; halted = 1; port 2 access still served; dbg_halt falls → port 0 granted next.
- rst_n pulsed high during ACCESS → ack never pulses, busy = 0, gnt_id = 3 immediately; after release, a pending port 0 req is granted first.
